booth_seq_mult: RTL and testbench

Iterative radix-4 Booth mantissa multiplier controller for the FPM datapath. It shares one Booth digit selector (3-bit digit plus 23-bit fraction in, 25-bit one's-complement partial product out) across all 13 digits of a 24-bit multiplier. It retires one digit per clock into a shifting accumulator and returns the exact 48-bit unsigned mantissa product. It sits between FPM operand unpack and normalize/round.

---
 rtl/booth_seq_mult.sv | 125 ++++++++++++
 tb/tb_booth_seq_mult.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-4 Booth mantissa multiplier, one digit per clock
// through a shared digit selector into a shifting accumulator; 48-bit unsigned product.

module booth_digit_sel #(
    parameter int FRAC_W = 23
) (
    input  logic [2:0]        i_x,
    input  logic [FRAC_W-1:0] i_y,
    output logic [FRAC_W+1:0] o_pp,
    output logic              o_neg
);
    logic              w_one;
    logic              w_two;
    logic [FRAC_W+1:0] w_mag;
    // One's-complement partial product; the caller supplies the +1 via o_neg.
    always_comb begin
        w_one = i_x[1] ^ i_x[0];
        w_two = (i_x == 3'b011) || (i_x == 3'b100);
        w_mag = w_one ? {2'b01, i_y} : w_two ? {1'b1, i_y, 1'b0} : '0;
        o_neg = i_x[2] & ~(i_x[1] & i_x[0]);
        o_pp  = o_neg ? ~w_mag : w_mag;
    end
endmodule

module booth_seq_mult #(
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAC_W-1:0]     a_frac,
    input  logic [FRAC_W-1:0]     b_frac,
    input  logic                  abort,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*FRAC_W+1:0]   product
);
    localparam int NDIG = (FRAC_W + 3) / 2;
    localparam int M_W  = FRAC_W + 4;
    localparam int PP_W = FRAC_W + 2;
    localparam int HI_W = FRAC_W + 5;
    localparam int LO_W = 2 * NDIG;
    localparam int P_W  = 2 * FRAC_W + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_k;
    logic [FRAC_W-1:0] r_a;
    logic [M_W-1:0]    r_m;
    logic [HI_W-1:0]   r_hi;
    logic [LO_W-1:0]   r_lo;
    logic [P_W-1:0]    r_product;
    logic [PP_W-1:0]   w_pp;
    logic              w_neg;
    logic [HI_W-1:0]   w_sum;
    logic [HI_W-1:0]   w_hi;
    logic [LO_W-1:0]   w_lo;
    logic              w_last;

    // r_m shifts right two bits per digit, so the current digit is always r_m[2:0].
    booth_digit_sel #(.FRAC_W(FRAC_W)) u_sel (
        .i_x   (r_m[2:0]),
        .i_y   (r_a),
        .o_pp  (w_pp),
        .o_neg (w_neg)
    );

    always_comb begin
        w_sum  = r_hi + {{(HI_W-PP_W){w_neg}}, w_pp} + HI_W'(w_neg);
        w_hi   = {{2{w_sum[HI_W-1]}}, w_sum[HI_W-1:2]};
        w_lo   = {w_sum[1:0], r_lo[LO_W-1:2]};
        w_last = r_k == 4'(NDIG - 1);
    end

    assign in_ready  = r_state == S_IDLE;
    assign busy      = r_state == S_RUN;
    assign out_valid = r_state == S_DONE;
    assign product   = r_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_a       <= '0;
            r_m       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_product <= '0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_a     <= a_frac;
                r_m     <= {2'b00, 1'b1, b_frac, 1'b0};
                r_hi    <= '0;
                r_lo    <= '0;
                r_k     <= '0;
                r_state <= S_RUN;
            end
        end else if (r_state == S_RUN) begin
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                r_hi <= w_hi;
                r_lo <= w_lo;
                r_m  <= r_m >> 2;
                r_k  <= r_k + 4'd1;
                if (w_last) begin
                    r_state   <= S_DONE;
                    r_product <= {w_hi[P_W-LO_W-1:0], w_lo};
                end
            end
        end else if (r_state == S_DONE) begin
            if (out_ready) r_state <= S_IDLE;
        end else begin
            r_state <= S_IDLE;
        end
    end

    // The product is below 2^48, so accumulator bits above it must be clear.
    a_hi_clear: assert property (@(posedge clk) disable iff (rst)
        (r_state == S_DONE) |-> (r_hi[HI_W-1:P_W-LO_W] == '0));
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and random checks of booth_seq_mult against an
// arithmetic reference, with a queue scoreboard matching accepts to products.

module tb_booth_seq_mult;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        abort;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] product;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] q[$];

    booth_seq_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_frac    (a_frac),
        .b_frac    (b_frac),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] ref_mul(input logic [22:0] a, input logic [22:0] b);
        return 48'({1'b1, a}) * 48'({1'b1, b});
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait for out_valid, checking latency and busy time.
    task automatic run_op(input logic [22:0] a, input logic [22:0] b);
        int n;
        int bc;
        a_frac   = a;
        b_frac   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n  = 0;
        bc = 0;
        while (!out_valid && n < 40) begin
            if (busy) bc++;
            step();
            n++;
        end
        chk("latency", 48'(n), 48'd13);
        chk("busy_cycles", 48'(bc), 48'd13);
        chk("prod_direct", product, ref_mul(a, b));
    endtask

    // Scoreboard: sampled on the falling edge, describing the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            q.delete();
        end else if (rst === 1'b0) begin
            if (in_valid && in_ready) q.push_back(ref_mul(a_frac, b_frac));
            if (busy && abort && q.size() > 0) void'(q.pop_back());
            if (out_valid && out_ready) begin
                chk("orphan_product", 48'(q.size() > 0), 48'd1);
                if (q.size() > 0) chk("sb_product", product, q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [47:0] saved;
        rst = 1'b1; in_valid = 1'b0; a_frac = '0; b_frac = '0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_ready", 48'(in_ready), 48'd1);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_product", product, 48'd0);

        run_op(23'h000000, 23'h000000);
        chk("one_x_one", product, 48'h4000_0000_0000);
        step();
        chk("ready_after_xfer", 48'(in_ready), 48'd1);
        run_op(23'h7FFFFF, 23'h7FFFFF);
        chk("max_x_max", product, 48'hFFFF_FE00_0001);
        step();
        run_op(23'h400000, 23'h400000);
        chk("1p5_sq", product, 48'h9000_0000_0000);
        step();
        run_op(23'h400000, 23'h000000);
        chk("1p5_x_1", product, 48'h6000_0000_0000);
        step();

        out_ready = 1'b0;
        run_op(23'h0ABCDE, 23'h13579B);
        saved = product;
        in_valid = 1'b1; a_frac = 23'h000001; b_frac = 23'h000002;
        repeat (20) begin
            step();
            chk("hold_valid", 48'(out_valid), 48'd1);
            chk("hold_product", product, saved);
            chk("hold_not_ready", 48'(in_ready), 48'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_hold_valid", 48'(out_valid), 48'd0);
        chk("post_hold_ready", 48'(in_ready), 48'd1);
        run_op(23'h2AAAAA, 23'h555555);
        step();

        a_frac = 23'h1F0F0F; b_frac = 23'h3C3C3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ready", 48'(in_ready), 48'd1);
        chk("abort_busy", 48'(busy), 48'd0);
        chk("abort_valid", 48'(out_valid), 48'd0);
        pulses = 0;
        repeat (16) begin step(); if (out_valid) pulses++; end
        chk("abort_no_pulse", 48'(pulses), 48'd0);

        a_frac = 23'h0F0F0F; b_frac = 23'h70F0F0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstrun_ready", 48'(in_ready), 48'd1);
        chk("rstrun_busy", 48'(busy), 48'd0);
        chk("rstrun_valid", 48'(out_valid), 48'd0);
        chk("rstrun_product", product, 48'd0);
        pulses = 0;
        repeat (16) begin step(); if (out_valid) pulses++; end
        chk("rstrun_no_pulse", 48'(pulses), 48'd0);
        run_op(23'h123456, 23'h654321);
        step();

        repeat (25000) begin
            in_valid  = 1'($urandom_range(0, 1));
            a_frac    = 23'($urandom);
            b_frac    = 23'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            abort     = $urandom_range(0, 31) == 0;
            step();
        end
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        chk("sb_drained", 48'(q.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
